ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
Streaming FIFO controller placed directly upstream of the 64x8 single-port RAM (ram_single_port). It accepts bytes on a valid/ready input and presents them in order on a valid/ready output. The RAM serves as circular storage and is driven through cs/we/addr/datain, with read data returned on dataout. Only one RAM access is issued per cycle: either a write or a read, never both.

Parameters:
AW, 6, RAM address width; DEPTH = 2**AW = 64 entries
DW, 8, data width; must match the RAM data width

Ports:
clk  in  1  system clock; all state updates on the posedge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  producer has a byte
in_ready  out  1  controller accepts the byte this cycle
in_data  in  DW  producer byte
out_valid  out  1  out_data holds the oldest byte
out_ready  in  1  consumer takes out_data this cycle
out_data  out  DW  output byte register
count  out  AW+1  bytes currently stored in RAM (0..DEPTH)
full  out  1  count == DEPTH
empty  out  1  no byte anywhere: RAM, in-flight fetch or output register
ram_cs  out  1  to RAM cs
ram_we  out  1  to RAM we
ram_addr  out  AW  to RAM addr
ram_wdata  out  DW  to RAM datain
ram_rdata  in  DW  from RAM dataout

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- RAM timing (fixed): cs=1, we=0 sampled at posedge N gives valid ram_rdata throughout cycle N+1. A write (cs=1, we=1) takes effect at the sampling posedge.
- State: wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[AW:0], fetch_pend, out_valid, out_data. FSM has two states:
  - IDLE: no fetch in flight.
  - FETCH: read issued last edge; ram_rdata is valid this cycle.
- slot_free = ~fetch_pend & (~out_valid | out_ready).
- Read issue (combinational) = rst_n & (count != 0) & slot_free. It drives ram_cs=1, ram_we=0, ram_addr=rd_ptr.
- At the edge after a read issue: rd_ptr+1 (mod DEPTH), count-1, go to FETCH.
- Write: in_ready = rst_n & ~full & ~read_issue. Reads take priority over writes.
  - On in_valid & in_ready: ram_cs=1, ram_we=1, ram_addr=wr_ptr, ram_wdata=in_data.
  - At the edge: wr_ptr+1 (mod DEPTH), count+1.
- count never increments and decrements in the same cycle.
- No RAM access: ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0.
- FETCH edge: out_data <= ram_rdata, out_valid <= 1, return to IDLE.
- Otherwise, out_valid & out_ready clears out_valid.
- While out_valid & ~out_ready, out_data and out_valid hold stable.
- Latency:
  - Write accepted at edge E into an empty FIFO gives read issue in cycle E+1 and out_valid=1 after edge E+2.
  - Sustained pop throughput is one byte every 2 cycles.
- Pointer wrap: 63 -> 0 with no gap. Byte order is strictly preserved across the wrap.
- Full: in_ready=0 and in_data is ignored; a read issue in the same cycle frees space from the next cycle.
- Empty with in_valid: write proceeds. Data is never bypassed around the RAM.
- Reset (rst_n=0 at an edge):
  - Pointers, count, fetch_pend and out_valid go to 0; out_data goes to 0; FSM goes to IDLE.
  - An in-flight fetch is discarded.
  - RAM contents are not cleared.
  - While rst_n=0: in_ready=0, ram_cs=0, ram_we=0.
- Reset values: in_ready=0, out_valid=0, out_data=0, count=0, full=0, empty=1, ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0.

Decomposition:
- Package ram_fifo_pkg holds:
  - constants AW=6, DW=8, DEPTH=64
  - state enum {IDLE, FETCH}
- No sub-module. ram_fifo_ctrl and ram_single_port are instantiated side by side in a thin top, ram_fifo_top, used by the bench.

Test Plan:
- Reset held 2 cycles with in_valid=1 -> in_ready=0, ram_cs=0, empty=1, count=0, out_valid=0.
- Push 0xA5, 0x3C, 0x7E, 0x01, 0xFF, 0x80 with out_ready=0 -> count reaches 5 after the first prefetch; out_data=0xA5 held. Then out_ready=1 -> the six bytes appear in order and empty=1 at the end.
- Push 64 bytes 0x00..0x3F with out_ready=0 -> one prefetch leaves count=63. Push 0x40 -> full=1, in_ready=0. A 66th byte 0x41 is refused and never observed.
- Back-pressure: out_valid=1 with out_ready=0 for 10 cycles -> out_data stable and no ram_cs read issued.
- Wrap: continuous push and pop of 200 incrementing bytes -> the output sequence equals the input sequence, ram_addr wraps 63 -> 0, count never exceeds 64.
- Reset asserted in the cycle after a read issue (FETCH) -> the fetched byte is dropped and out_valid=0. After release, pushing 0x55 gives out_data=0x55 within 3 cycles.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// Shared constants and FSM encoding for the RAM-backed streaming FIFO.
// The default sizes match the 64x8 single-port RAM that sits behind the controller.
package ram_fifo_pkg;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fifo_state_e;

endpackage

// File: rtl/ram_single_port.sv
// 64x8 single-port RAM: writes land at the sampling edge, and reads return data
// through a register that is valid for the whole following cycle.
module ram_single_port (
    input  logic                          i_clk,
    input  logic                          i_cs,
    input  logic                          i_we,
    input  logic [ram_fifo_pkg::AW-1:0]   i_addr,
    input  logic [ram_fifo_pkg::DW-1:0]   i_datain,
    output logic [ram_fifo_pkg::DW-1:0]   o_dataout
);

    logic [ram_fifo_pkg::DW-1:0] r_mem [ram_fifo_pkg::DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_cs) begin
            if (i_we) begin
                r_mem[i_addr] <= i_datain;
            end else begin
                o_dataout <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller that uses an external single-port RAM as circular storage
// and prefetches the oldest byte into an output register.
module ram_fifo_ctrl #(
    parameter int unsigned AW = ram_fifo_pkg::AW,
    parameter int unsigned DW = ram_fifo_pkg::DW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_ram_cs,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);

    import ram_fifo_pkg::*;

    fifo_state_e   r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;

    logic w_fetch_pend;
    logic w_full;
    logic w_slot_free;
    logic w_rd_issue;
    logic w_wr_issue;

    assign w_fetch_pend = (r_state == FETCH);
    // r_count never exceeds DEPTH, so its top bit alone marks full.
    assign w_full       = r_count[AW];
    assign w_slot_free  = ~w_fetch_pend & (~r_out_valid | i_out_ready);
    assign w_rd_issue   = i_rst_n & (r_count != '0) & w_slot_free;
    assign o_in_ready   = i_rst_n & ~w_full & ~w_rd_issue;
    assign w_wr_issue   = i_in_valid & o_in_ready;

    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_count      = r_count;
    assign o_full       = w_full;
    assign o_empty      = (r_count == '0) & ~w_fetch_pend & ~r_out_valid;

    // One RAM access per cycle; a pending read always wins over a write.
    always_comb begin
        o_ram_cs    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (w_rd_issue) begin
            o_ram_cs   = 1'b1;
            o_ram_addr = r_rd_ptr;
        end else if (w_wr_issue) begin
            o_ram_cs    = 1'b1;
            o_ram_we    = 1'b1;
            o_ram_addr  = r_wr_ptr;
            o_ram_wdata = i_in_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end else if (w_wr_issue) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_rd_issue) begin
                        r_state <= FETCH;
                    end
                    if (r_out_valid && i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                FETCH: begin
                    r_state     <= IDLE;
                    r_out_data  <= i_ram_rdata;
                    r_out_valid <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl wired to the single-port RAM: a scoreboard queue is filled
// on accepted writes and drained by a monitor on every output handshake.
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [6:0] count;
    logic       full;
    logic       empty;
    logic       ram_cs;
    logic       ram_we;
    logic [5:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb[$];

    int         exp_count  = 0;
    logic [5:0] exp_waddr  = '0;
    logic [5:0] exp_raddr  = '0;
    logic [5:0] last_waddr = '0;
    logic [5:0] last_raddr = '0;
    bit         saw_wwrap  = 1'b0;
    bit         saw_rwrap  = 1'b0;
    int         max_cnt    = 0;

    ram_fifo_ctrl #(.AW(6), .DW(8)) u_ctrl (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (empty),
        .o_ram_cs    (ram_cs),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    ram_single_port u_ram (
        .i_clk     (clk),
        .i_cs      (ram_cs),
        .i_we      (ram_we),
        .i_addr    (ram_addr),
        .i_datain  (ram_wdata),
        .o_dataout (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: got in_ready=0, want 1 for byte 0x%0h", d);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        tick();
        out_ready = 1'b1;
        while (!empty && n < budget) begin
            tick();
            n++;
        end
        chk("drain_empty", empty, 1);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    // Scoreboard fill: every accepted write is expected later on the output.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back(in_data);
        end
    end

    // Output monitor: every handshake must deliver the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_unexpected: got 0x%0h, want no output", out_data);
            end else begin
                chk("out_data", out_data, sb.pop_front());
            end
        end
    end

    // RAM bus monitor with an independent pointer/count model.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_count  = 0;
            exp_waddr  = '0;
            exp_raddr  = '0;
            last_waddr = '0;
            last_raddr = '0;
        end else begin
            chk("count", count, exp_count);
            chk("full", full, exp_count == 64);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (ram_cs && ram_we) begin
                chk("waddr", ram_addr, exp_waddr);
                chk("wdata", ram_wdata, in_data);
                if (last_waddr == 6'd63 && ram_addr == 6'd0) saw_wwrap = 1'b1;
                last_waddr = ram_addr;
                exp_waddr  = exp_waddr + 6'd1;
                exp_count  = exp_count + 1;
            end else if (ram_cs) begin
                chk("raddr", ram_addr, exp_raddr);
                if (last_raddr == 6'd63 && ram_addr == 6'd0) saw_rwrap = 1'b1;
                last_raddr = ram_addr;
                exp_raddr  = exp_raddr + 6'd1;
                exp_count  = exp_count - 1;
            end else begin
                chk("idle_bus", {ram_we, ram_addr, ram_wdata}, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] t2 [6];
        int lat;
        t2 = '{8'hA5, 8'h3C, 8'h7E, 8'h01, 8'hFF, 8'h80};

        // Reset with a producer already waving data.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Six bytes with a stalled consumer: first is prefetched, five stay in RAM.
        foreach (t2[i]) push(t2[i]);
        @(negedge clk);
        chk("t2_count", count, 5);
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_data", out_data, 8'hA5);

        // Back-pressure: output stays put and no read is issued.
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("bp_out_data", out_data, 8'hA5);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_no_read", ram_cs, 0);
        end
        drain(40);
        out_ready = 1'b0;

        // Fill to full: 64 bytes leave count=63 after one prefetch, the 65th fills it.
        for (int i = 0; i < 64; i++) push(8'(i));
        @(negedge clk);
        chk("t3_count63", count, 63);
        chk("t3_not_full", full, 0);
        chk("t3_head", out_data, 8'h00);
        tick();
        push(8'h40);
        @(negedge clk);
        chk("t3_full", full, 1);
        chk("t3_count64", count, 64);
        chk("t3_in_ready", in_ready, 0);
        tick();
        in_valid = 1'b1;
        in_data  = 8'h41;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_refuse_ready", in_ready, 0);
            chk("t3_refuse_bus", ram_cs, 0);
            tick();
        end
        in_valid = 1'b0;
        drain(200);

        // Streaming across the pointer wrap.
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) push(8'(i));
        drain(100);
        chk("t4_wr_wrap", saw_wwrap, 1);
        chk("t4_rd_wrap", saw_rwrap, 1);
        chk("t4_max_count", max_cnt <= 64, 1);

        // Reset during FETCH drops the in-flight byte.
        out_ready = 1'b0;
        push(8'h77);
        @(negedge clk);
        chk("t6_read_issue", {ram_cs, ram_we}, 2'b10);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_ram_cs", ram_cs, 0);
        tick();
        @(negedge clk);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push(8'h55);
        lat = 0;
        while (!out_valid && lat < 3) begin
            tick();
            lat++;
        end
        chk("t6_latency", lat, 2);
        chk("t6_out_55", out_data, 8'h55);
        drain(10);

        chk("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
